// File: rtl/lcd_bus_arbiter.sv
// Character-LCD write-bus owner: runs the power-up init sequence, then
// round-robin arbitrates single-byte writes from two clients and generates
// all E-strobe setup/pulse/hold and post-command wait timing.
module lcd_bus_arbiter #(
  parameter int POWERUP_CYC = 20000,
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int HOLD_CYC    = 2,
  parameter int CMD_WAIT    = 50,
  parameter int CLR_WAIT    = 2000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       req0_i,
  input  logic       rs0_i,
  input  logic [7:0] data0_i,
  output logic       ack0_o,
  input  logic       req1_i,
  input  logic       rs1_i,
  input  logic [7:0] data1_i,
  output logic       ack1_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       lcd_e_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  // The shared down-counter must hold the largest duration of any state.
  localparam int MaxA = (POWERUP_CYC > CLR_WAIT) ? POWERUP_CYC : CLR_WAIT;
  localparam int MaxB = (MaxA > CMD_WAIT) ? MaxA : CMD_WAIT;
  localparam int MaxC = (MaxB > SETUP_CYC) ? MaxB : SETUP_CYC;
  localparam int MaxD = (MaxC > PULSE_CYC) ? MaxC : PULSE_CYC;
  localparam int MaxE = (MaxD > HOLD_CYC) ? MaxD : HOLD_CYC;
  localparam int CW   = $clog2(MaxE + 1);

  localparam logic [CW-1:0] PwrLoad   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SetupLoad = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PulseLoad = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HoldLoad  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CmdLoad   = CW'(CMD_WAIT - 1);
  localparam logic [CW-1:0] ClrLoad   = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    initIdx_q, initIdx_d;
  logic          lastGrant_q, lastGrant_d;
  logic          ready_q, ready_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic          lcdE_q, lcdE_d;
  logic          lcdRs_q, lcdRs_d;
  logic [7:0]    lcdData_q, lcdData_d;
  logic          busy_q, busy_d;
  logic          cntZero;
  logic          isClear;
  logic          grant1;

  assign cntZero = (cnt_q == '0);
  assign isClear = !lcdRs_q && ((lcdData_q == 8'h01) || (lcdData_q == 8'h02));
  assign grant1  = req1_i && (!req0_i || !lastGrant_q);

  // Next-state logic: sequence timing states, init command loading and arbitration.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    initIdx_d   = initIdx_q;
    lastGrant_d = lastGrant_q;
    ready_d     = ready_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    lcdRs_d     = lcdRs_q;
    lcdData_d   = lcdData_q;
    case (state_q)
      PWR_WAIT: begin
        if (cntZero) state_d = INIT_LOAD;
        else         cnt_d   = cnt_q - CntOne;
      end
      INIT_LOAD: begin
        lcdRs_d = 1'b0;
        case (initIdx_q[1:0])
          2'd0:    lcdData_d = 8'h38;
          2'd1:    lcdData_d = 8'h0C;
          2'd2:    lcdData_d = 8'h06;
          default: lcdData_d = 8'h01;
        endcase
        initIdx_d = initIdx_q + 3'd1;
        state_d   = SETUP;
        cnt_d     = SetupLoad;
      end
      SETUP: begin
        if (cntZero) begin
          state_d = PULSE;
          cnt_d   = PulseLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      PULSE: begin
        if (cntZero) begin
          state_d = HOLD;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      HOLD: begin
        if (cntZero) begin
          state_d = WAIT;
          cnt_d   = isClear ? ClrLoad : CmdLoad;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      WAIT: begin
        if (!cntZero) begin
          cnt_d = cnt_q - CntOne;
        end else if (ready_q) begin
          state_d = IDLE;
        end else if (initIdx_q == 3'd4) begin
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = INIT_LOAD;
        end
      end
      IDLE: begin
        if (ready_q && (req0_i || req1_i)) begin
          if (grant1) begin
            ack1_d      = 1'b1;
            lcdRs_d     = rs1_i;
            lcdData_d   = data1_i;
            lastGrant_d = 1'b1;
          end else begin
            ack0_d      = 1'b1;
            lcdRs_d     = rs0_i;
            lcdData_d   = data0_i;
            lastGrant_d = 1'b0;
          end
          state_d = SETUP;
          cnt_d   = SetupLoad;
        end
      end
      default: state_d = PWR_WAIT;
    endcase
  end

  // Registered strobe and busy flag, derived from the state being entered.
  always_comb begin
    lcdE_d = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops E and all handshakes immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PWR_WAIT;
      cnt_q       <= PwrLoad;
      initIdx_q   <= 3'd0;
      lastGrant_q <= 1'b1;
      ready_q     <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      lcdE_q      <= 1'b0;
      lcdRs_q     <= 1'b0;
      lcdData_q   <= 8'h00;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      initIdx_q   <= initIdx_d;
      lastGrant_q <= lastGrant_d;
      ready_q     <= ready_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      lcdE_q      <= lcdE_d;
      lcdRs_q     <= lcdRs_d;
      lcdData_q   <= lcdData_d;
      busy_q      <= busy_d;
    end
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign lcd_e_o    = lcdE_q;
  assign lcd_rs_o   = lcdRs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_data_o = lcdData_q;

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Testbench for lcd_bus_arbiter: directed scenarios plus a randomized
// two-client run checked against a cycle-timeline reference model.
module tb_lcd_bus_arbiter;

  localparam int PWR  = 10;
  localparam int SET  = 1;
  localparam int PUL  = 2;
  localparam int HLD  = 1;
  localparam int CMDW = 3;
  localparam int CLRW = 8;
  localparam logic [7:0] INIT_CMDS [4] = '{8'h38, 8'h0C, 8'h06, 8'h01};
  localparam logic [14:0] RESET_VEC = 15'b000_00000000_0001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, ready, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int cyc = 0;
  int nChecks = 0;
  int nFails = 0;
  int lastWin = 1;

  lcd_bus_arbiter #(
    .POWERUP_CYC(PWR), .SETUP_CYC(SET), .PULSE_CYC(PUL),
    .HOLD_CYC(HLD), .CMD_WAIT(CMDW), .CLR_WAIT(CLRW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req0_i(req0), .rs0_i(rs0), .data0_i(data0), .ack0_o(ack0),
    .req1_i(req1), .rs1_i(rs1), .data1_i(data1), .ack1_o(ack1),
    .ready_o(ready), .busy_o(busy),
    .lcd_e_o(lcd_e), .lcd_rs_o(lcd_rs), .lcd_rw_o(lcd_rw), .lcd_data_o(lcd_data)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Hard stop in case something hangs.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int waitFor(input logic rs, input logic [7:0] d);
    return (!rs && (d == 8'h01 || d == 8'h02)) ? CLRW : CMDW;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    nChecks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy} !== RESET_VEC) begin
      nFails++;
      $display("[TB] FAIL reset_values: got %b want %b",
               {lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy}, RESET_VEC);
    end
    repeat (3) @(negedge clk);
    nChecks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy} !== RESET_VEC) begin
      nFails++;
      $display("[TB] FAIL reset_held: got %b want %b",
               {lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy}, RESET_VEC);
    end
    lastWin = 1;
  endtask

  // Releases reset and checks the init command timeline cycle by cycle.
  task automatic test_init_sequence;
    int rise [4];
    int t, fin, readyAt, k;
    logic expE, expReady;
    t = PWR + 1 + SET;
    fin = 0;
    for (int i = 0; i < 4; i++) begin
      rise[i] = t;
      fin = t + PUL + HLD + waitFor(1'b0, INIT_CMDS[i]);
      t = fin + 1 + SET;
    end
    readyAt = fin;
    @(negedge clk);
    rst_n = 1'b1;
    for (int off = 1; off <= readyAt; off++) begin
      @(negedge clk);
      expE = 1'b0;
      k = 0;
      for (int i = 0; i < 4; i++)
        if (off >= rise[i] && off < rise[i] + PUL) begin
          expE = 1'b1;
          k = i;
        end
      expReady = (off >= readyAt);
      nChecks++;
      if (lcd_e !== expE) begin
        nFails++;
        $display("[TB] FAIL init_e: offset %0d got %b want %b", off, lcd_e, expE);
      end
      nChecks++;
      if (ready !== expReady || busy !== !expReady) begin
        nFails++;
        $display("[TB] FAIL init_ready_busy: offset %0d got %b%b want %b%b",
                 off, ready, busy, expReady, !expReady);
      end
      nChecks++;
      if ({ack0, ack1, lcd_rw} !== 3'b000) begin
        nFails++;
        $display("[TB] FAIL init_no_ack: offset %0d got %b want 000", off, {ack0, ack1, lcd_rw});
      end
      if (expE) begin
        nChecks++;
        if ({lcd_rs, lcd_data} !== {1'b0, INIT_CMDS[k]}) begin
          nFails++;
          $display("[TB] FAIL init_cmd: offset %0d got %h want %h",
                   off, {lcd_rs, lcd_data}, {1'b0, INIT_CMDS[k]});
        end
      end
    end
    lastWin = 1;
  endtask

  task automatic test_withdraw;
    @(negedge clk);
    req1 = 1'b1;
    rs1 = 1'b1;
    data1 = 8'h55;
    #2;
    req1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      nChecks++;
      if ({ack1, lcd_e, busy} !== 3'b000) begin
        nFails++;
        $display("[TB] FAIL withdraw: cycle %0d got ack1/e/busy=%b want 000", k, {ack1, lcd_e, busy});
      end
    end
  endtask

  task automatic test_clear_wait;
    logic       cRs [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [7:0] cDat [4] = '{8'h01, 8'h02, 8'h01, 8'h03};
    int w;
    for (int n = 0; n < 4; n++) begin
      w = (n < 2) ? CLRW : CMDW;
      req1 = 1'b1;
      rs1 = cRs[n];
      data1 = cDat[n];
      @(negedge clk);
      nChecks++;
      if ({ack0, ack1, lcd_rs, lcd_data} !== {1'b0, 1'b1, cRs[n], cDat[n]}) begin
        nFails++;
        $display("[TB] FAIL clear_accept: case %0d got %h want %h", n,
                 {ack0, ack1, lcd_rs, lcd_data}, {1'b0, 1'b1, cRs[n], cDat[n]});
      end
      req1 = 1'b0;
      for (int k = 1; k <= SET + PUL + HLD + w; k++) begin
        @(negedge clk);
        nChecks++;
        if (busy !== (k < SET + PUL + HLD + w) || lcd_e !== (k >= SET && k < SET + PUL) || ack1 !== 1'b0) begin
          nFails++;
          $display("[TB] FAIL clear_wait: case %0d cycle %0d got busy/e/ack1=%b%b%b want %b%b0", n, k,
                   busy, lcd_e, ack1, (k < SET + PUL + HLD + w), (k >= SET && k < SET + PUL));
        end
      end
    end
    lastWin = 1;
  endtask

  task automatic test_back_to_back;
    int ackCyc [4];
    int ackWho [4];
    int nAck;
    int expWho;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'hA0;
    req1 = 1'b1; rs1 = 1'b1; data1 = 8'hB1;
    nAck = 0;
    for (int k = 0; k < 60 && nAck < 4; k++) begin
      @(negedge clk);
      if (ack0 && ack1) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL b2b_both_ack: cycle %0d got 11 want one-hot", cyc);
      end else if (ack0 || ack1) begin
        ackCyc[nAck] = cyc;
        ackWho[nAck] = ack1 ? 1 : 0;
        nChecks++;
        if ({lcd_rs, lcd_data} !== (ack1 ? {1'b1, 8'hB1} : {1'b1, 8'hA0})) begin
          nFails++;
          $display("[TB] FAIL b2b_data: ack %0d got %h", nAck, {lcd_rs, lcd_data});
        end
        nAck++;
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    nChecks++;
    if (nAck != 4) begin
      nFails++;
      $display("[TB] FAIL b2b_count: got %0d acks want 4", nAck);
    end else begin
      expWho = 1 - lastWin;
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if (ackWho[i] != expWho) begin
          nFails++;
          $display("[TB] FAIL b2b_order: ack %0d got client %0d want %0d", i, ackWho[i], expWho);
        end
        if (i > 0) begin
          nChecks++;
          if (ackCyc[i] - ackCyc[i-1] != SET + PUL + HLD + CMDW + 1) begin
            nFails++;
            $display("[TB] FAIL b2b_spacing: ack %0d got %0d want %0d", i,
                     ackCyc[i] - ackCyc[i-1], SET + PUL + HLD + CMDW + 1);
          end
        end
        expWho = 1 - expWho;
      end
      lastWin = ackWho[3];
    end
    for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL b2b_idle: got busy=%b want 0", busy);
    end
  endtask

  // Random traffic; expected waveform derived from per-transaction timing arithmetic.
  task automatic test_random;
    logic       pend [2];
    logic       prs [2];
    logic [7:0] pdat [2];
    int idleAt, ackAt, ackWho, eS, eE, rr, a, c, win;
    logic       latRs;
    logic [7:0] latData;
    pend[0] = 1'b0; pend[1] = 1'b0;
    prs[0] = 1'b0; prs[1] = 1'b0;
    pdat[0] = 8'h00; pdat[1] = 8'h00;
    idleAt = cyc; ackAt = -1; ackWho = 0; eS = -1; eE = -1; rr = lastWin;
    latRs = 1'b0; latData = 8'h00;
    for (int it = 0; it < 900; it++) begin
      c = cyc;
      nChecks++;
      if (ack0 !== (ackAt == c && ackWho == 0) || ack1 !== (ackAt == c && ackWho == 1)) begin
        nFails++;
        $display("[TB] FAIL rand_ack: cycle %0d got %b%b want %b%b", c, ack0, ack1,
                 (ackAt == c && ackWho == 0), (ackAt == c && ackWho == 1));
      end
      nChecks++;
      if (lcd_e !== (c >= eS && c < eE) || busy !== (c < idleAt)) begin
        nFails++;
        $display("[TB] FAIL rand_e_busy: cycle %0d got %b%b want %b%b", c, lcd_e, busy,
                 (c >= eS && c < eE), (c < idleAt));
      end
      if (ackAt >= 0 && c >= ackAt) begin
        nChecks++;
        if ({lcd_rs, lcd_data} !== {latRs, latData}) begin
          nFails++;
          $display("[TB] FAIL rand_data: cycle %0d got %h want %h", c, {lcd_rs, lcd_data}, {latRs, latData});
        end
      end
      if (ackAt == c) pend[ackWho] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if ($urandom_range(3, 0) == 0) begin
            pend[p] = 1'b1;
            prs[p] = 1'($urandom_range(1, 0));
            if ($urandom_range(3, 0) == 0) pdat[p] = ($urandom_range(1, 0) == 0) ? 8'h01 : 8'h02;
            else                           pdat[p] = 8'($urandom);
          end
        end else if ($urandom_range(31, 0) == 0) begin
          pend[p] = 1'b0;
        end
      end
      req0 = pend[0]; rs0 = prs[0]; data0 = pdat[0];
      req1 = pend[1]; rs1 = prs[1]; data1 = pdat[1];
      if (c >= idleAt && (pend[0] || pend[1])) begin
        win = (pend[0] && pend[1]) ? 1 - rr : (pend[1] ? 1 : 0);
        rr = win;
        a = c + 1;
        ackAt = a;
        ackWho = win;
        latRs = prs[win];
        latData = pdat[win];
        eS = a + SET;
        eE = eS + PUL;
        idleAt = a + SET + PUL + HLD + waitFor(latRs, latData);
      end
      @(negedge clk);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    lastWin = rr;
    for (int k = 0; k < 40 && busy !== 1'b0; k++) @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL rand_idle: got busy=%b want 0", busy);
    end
  endtask

  // Reset mid-strobe, rerun init with client 0 requesting, then check its first grant.
  task automatic test_mid_reset;
    logic sawE;
    req0 = 1'b1; rs0 = 1'b1; data0 = 8'h5A;
    sawE = 1'b0;
    for (int k = 0; k < 10 && !sawE; k++) begin
      @(negedge clk);
      sawE = (lcd_e === 1'b1);
    end
    nChecks++;
    if (!sawE) begin
      nFails++;
      $display("[TB] FAIL midrst_strobe: got no E pulse want E=1 within 10 cycles");
    end
    #1;
    rst_n = 1'b0;
    data0 = 8'h31;
    #1;
    nChecks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy} !== RESET_VEC) begin
      nFails++;
      $display("[TB] FAIL midrst_values: got %b want %b",
               {lcd_e, lcd_rs, lcd_rw, lcd_data, ack0, ack1, ready, busy}, RESET_VEC);
    end
    repeat (2) @(negedge clk);
    test_init_sequence();
    @(negedge clk);
    nChecks++;
    if ({ack0, ack1, lcd_rs, lcd_data} !== {1'b1, 1'b0, 1'b1, 8'h31}) begin
      nFails++;
      $display("[TB] FAIL first_grant: got %h want %h", {ack0, ack1, lcd_rs, lcd_data},
               {1'b1, 1'b0, 1'b1, 8'h31});
    end
    req0 = 1'b0;
    for (int k = 1; k <= SET + PUL; k++) begin
      @(negedge clk);
      nChecks++;
      if (ack0 !== 1'b0 || lcd_e !== (k >= SET && k < SET + PUL)) begin
        nFails++;
        $display("[TB] FAIL first_grant_strobe: cycle %0d got ack0/e=%b%b want 0%b",
                 k, ack0, lcd_e, (k >= SET && k < SET + PUL));
      end
    end
    for (int k = 0; k < 20 && busy !== 1'b0; k++) @(negedge clk);
    nChecks++;
    if (busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL first_grant_idle: got busy=%b want 0", busy);
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] starting lcd_bus_arbiter bench");
    test_reset();
    test_init_sequence();
    test_withdraw();
    test_clear_wait();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
